// File: rtl/entry_sequencer_iceqman.sv
`default_nettype none
// +--------------------------------------------------------------------------------+
// | entry_sequencer_iceqman : replays a script of opcode/operand byte entries and  |
// | self-checks results. Option macro SEQ_CHECK_EN stores/compares expected. r1.0  |
// +--------------------------------------------------------------------------------+
module entry_sequencer_iceqman #(
   parameter int  DEPTH   = 16,
   parameter int  GAP     = 4,
   parameter int  TIMEOUT = 1024,
   localparam int AW      = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          wr_en_i,
   input  logic [AW-1:0] wr_addr_i,
   input  logic [35:0]   wr_data_i,
   input  logic [AW:0]   len_i,
   input  logic          start_i,
   input  logic          step_mode_i,
   input  logic          advance_i,
   output logic [7:0]    data_o,
   output logic          press_o,
   input  logic          result_valid_i,
   input  logic [15:0]   result_i,
   output logic          busy_o,
   output logic          done_o,
   output logic [AW:0]   index_o,
   output logic [15:0]   last_result_o,
   output logic [7:0]    pass_cnt_o,
   output logic [7:0]    fail_cnt_o,
   output logic          timeout_o,
   output logic [4:0]    state_o
);

`ifdef SEQ_CHECK_EN
   localparam int EW = 36;
`else
   localparam int EW = 20;
   logic unused_exp;
   assign unused_exp = ^wr_data_i[35:20];
`endif

   localparam int          TW      = $clog2(GAP + TIMEOUT + 2);
   localparam logic [TW-1:0] GAP_C = TW'(GAP);
   localparam logic [TW-1:0] TO_C  = TW'(TIMEOUT - 1);
   localparam logic [TW-1:0] TONE  = TW'(1);
   localparam logic [AW:0]   IONE  = {{AW{1'b0}}, 1'b1};

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_LOAD     = 3'd1,
      S_SEND_OP  = 3'd2,
      S_SEND_A   = 3'd3,
      S_SEND_B   = 3'd4,
      S_WAIT_RES = 3'd5,
      S_CHECK    = 3'd6,
      S_DONE     = 3'd7
   } state_t;

   state_t          state_q, state_d;
   logic [TW-1:0]   tmr_q, tmr_d;
   logic [AW:0]     index_q, index_d;
   logic [AW:0]     len_q, len_d;
   logic [EW-1:0]   entry_q, entry_d;
   logic [7:0]      pass_q, pass_d;
   logic [7:0]      fail_q, fail_d;
   logic            to_q, to_d;
   logic [15:0]     res_q, res_d;
   logic [7:0]      data_q, data_d;
   logic [EW-1:0]   mem_q [DEPTH];

   logic [AW:0]     index_inc;
   logic            last_entry;
   logic            advance;
   logic            match;
   logic [7:0]      send_byte;

   function automatic logic [7:0] sat_inc(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

`ifdef SEQ_CHECK_EN
   assign match = (res_q == entry_q[35:20]);
`else
   assign match = 1'b1;
`endif

   assign index_inc  = index_q + IONE;
   assign last_entry = (index_inc == len_q);
   // Strobe cycle has tmr_q == 0, so an advance pulse coincident with the strobe is ignored.
   assign advance    = step_mode_i ? ((tmr_q != '0) && advance_i) : (tmr_q == GAP_C);

   always_comb begin
      send_byte = entry_q[19:12];
      case (state_q)
         S_SEND_OP: send_byte = {4'b0000, entry_q[3:0]};
         S_SEND_A:  send_byte = entry_q[11:4];
         default:   send_byte = entry_q[19:12];
      endcase
   end

   always_ff @(posedge clk) begin
      if (wr_en_i && (state_q == S_IDLE)) begin
         mem_q[wr_addr_i] <= wr_data_i[EW-1:0];
      end
   end

   always_comb begin
      state_d = state_q;
      tmr_d   = (&tmr_q) ? tmr_q : tmr_q + TONE;
      index_d = index_q;
      len_d   = len_q;
      entry_d = entry_q;
      pass_d  = pass_q;
      fail_d  = fail_q;
      to_d    = to_q;
      res_d   = res_q;
      data_d  = data_q;
      press_o = 1'b0;
      done_o  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start_i) begin
               index_d = '0;
               pass_d  = 8'h00;
               fail_d  = 8'h00;
               to_d    = 1'b0;
               len_d   = len_i;
               state_d = (len_i == '0) ? S_DONE : S_LOAD;
            end
         end
         S_LOAD: begin
            entry_d = mem_q[index_q[AW-1:0]];
            state_d = S_SEND_OP;
         end
         S_SEND_OP, S_SEND_A, S_SEND_B: begin
            if (tmr_q == '0) begin
               press_o = 1'b1;
               data_d  = send_byte;
            end
            if (advance) begin
               case (state_q)
                  S_SEND_OP: state_d = S_SEND_A;
                  S_SEND_A:  state_d = S_SEND_B;
                  default:   state_d = S_WAIT_RES;
               endcase
            end
         end
         S_WAIT_RES: begin
            if (result_valid_i) begin
               res_d   = result_i;
               state_d = S_CHECK;
            end else if (tmr_q == TO_C) begin
               to_d    = 1'b1;
               fail_d  = sat_inc(fail_q);
               index_d = index_inc;
               state_d = last_entry ? S_DONE : S_LOAD;
            end
         end
         S_CHECK: begin
            if (match) pass_d = sat_inc(pass_q);
            else       fail_d = sat_inc(fail_q);
            index_d = index_inc;
            state_d = last_entry ? S_DONE : S_LOAD;
         end
         S_DONE: begin
            done_o  = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
      if (state_d != state_q) tmr_d = '0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         tmr_q   <= '0;
         index_q <= '0;
         len_q   <= '0;
         entry_q <= '0;
         pass_q  <= 8'h00;
         fail_q  <= 8'h00;
         to_q    <= 1'b0;
         res_q   <= 16'h0000;
         data_q  <= 8'h00;
      end else begin
         state_q <= state_d;
         tmr_q   <= tmr_d;
         index_q <= index_d;
         len_q   <= len_d;
         entry_q <= entry_d;
         pass_q  <= pass_d;
         fail_q  <= fail_d;
         to_q    <= to_d;
         res_q   <= res_d;
         data_q  <= data_d;
      end
   end

   // data_o follows the new byte in its strobe cycle, then holds it.
   assign data_o        = data_d;
   assign busy_o        = (state_q != S_IDLE);
   assign index_o       = index_q;
   assign last_result_o = res_q;
   assign pass_cnt_o    = pass_q;
   assign fail_cnt_o    = fail_q;
   assign timeout_o     = to_q;
   assign state_o       = {2'b00, state_q};

endmodule
`default_nettype wire

// File: tb/tb_entry_sequencer_iceqman.sv
`default_nettype none
// +--------------------------------------------------------------------------------+
// | tb_entry_sequencer_iceqman : randomized script runs against a timing model.    |
// | r1.0                                                                           |
// +--------------------------------------------------------------------------------+
module tb_entry_sequencer_iceqman;
   localparam int DEPTH   = 16;
   localparam int GAP     = 4;
   localparam int TIMEOUT = 20;
   localparam int AW      = 4;
`ifdef SEQ_CHECK_EN
   localparam bit CHK_EN = 1'b1;
`else
   localparam bit CHK_EN = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst;
   logic wr_en_i, start_i, step_mode_i, advance_i, result_valid_i;
   logic [AW-1:0] wr_addr_i;
   logic [35:0] wr_data_i;
   logic [AW:0] len_i;
   logic [15:0] result_i;
   logic [7:0] data_o, pass_cnt_o, fail_cnt_o;
   logic press_o, busy_o, done_o, timeout_o;
   logic [AW:0] index_o;
   logic [15:0] last_result_o;
   logic [4:0] state_o;

   always #5 clk = ~clk;

   entry_sequencer_iceqman #(.DEPTH(DEPTH), .GAP(GAP), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .rst(rst),
      .wr_en_i(wr_en_i), .wr_addr_i(wr_addr_i), .wr_data_i(wr_data_i),
      .len_i(len_i), .start_i(start_i), .step_mode_i(step_mode_i), .advance_i(advance_i),
      .data_o(data_o), .press_o(press_o),
      .result_valid_i(result_valid_i), .result_i(result_i),
      .busy_o(busy_o), .done_o(done_o), .index_o(index_o), .last_result_o(last_result_o),
      .pass_cnt_o(pass_cnt_o), .fail_cnt_o(fail_cnt_o), .timeout_o(timeout_o), .state_o(state_o)
   );

   int n_checks = 0;
   int n_fail   = 0;
   logic [35:0] scr [DEPTH];
   int          rdly [DEPTH];   // -1: never answer
   logic [15:0] rval [DEPTH];
   bit          early [DEPTH];  // also pulse a stray result during the SEND_B strobe
   logic [7:0]  m_data = 8'h00;
   logic [15:0] m_last = 16'h0000;

   task automatic check_eq(input string tag, input logic [35:0] got, input logic [35:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [7:0] byte_of(input logic [35:0] e, input int j);
      if (j == 0) return {4'h0, e[3:0]};
      if (j == 1) return e[11:4];
      return e[19:12];
   endfunction

   task automatic write_entry(input int a, input logic [35:0] d);
      wr_en_i = 1'b1; wr_addr_i = 4'(a); wr_data_i = d;
      tick();
      wr_en_i = 1'b0;
   endtask

   // Run n entries; cycle r=1 is the first cycle after start_i is sampled.
   task automatic do_run(input int n, input bit wr_with_start, input logic [35:0] wdata);
      int L [DEPTH];
      int V [DEPTH];
      int t, D, e_pass, e_fail;
      bit e_to, ep, v;
      logic [7:0] eb;
      logic [15:0] rv;
      if (wr_with_start) scr[0] = wdata;
      t = 1; e_pass = 0; e_fail = 0; e_to = 0;
      for (int k = 0; k < n; k++) begin
         L[k] = t;
         if (rdly[k] >= 0) begin
            V[k]   = t + 3 * GAP + 4 + rdly[k];
            m_last = rval[k];
            if (!CHK_EN || rval[k] == scr[k][35:20]) e_pass++;
            else e_fail++;
            t = V[k] + 2;
         end else begin
            V[k] = -1;
            e_fail++;
            e_to = 1;
            t = t + 3 * GAP + 4 + TIMEOUT;
         end
      end
      D = t;
      start_i = 1'b1; len_i = 5'(n);
      if (wr_with_start) begin
         wr_en_i = 1'b1; wr_addr_i = '0; wr_data_i = wdata;
      end
      tick();
      start_i = 1'b0; wr_en_i = 1'b0; len_i = 5'($urandom);
      for (int r = 1; r <= D + 1; r++) begin
         ep = 0; eb = 8'h00; v = 0; rv = 16'($urandom);
         for (int k = 0; k < n; k++) begin
            for (int j = 0; j < 3; j++) begin
               if (r == L[k] + 1 + j * (GAP + 1)) begin
                  ep = 1;
                  eb = byte_of(scr[k], j);
               end
            end
            if (r == V[k]) begin
               v  = 1;
               rv = rval[k];
            end
            if (early[k] && r == L[k] + 1 + 2 * (GAP + 1)) v = 1;
         end
         if (ep) m_data = eb;
         check_eq("press", press_o, ep);
         check_eq("data", data_o, m_data);
         check_eq("done", done_o, r == D);
         check_eq("busy", busy_o, r <= D);
         result_valid_i = v; result_i = rv;
         wr_en_i = (r == 3); start_i = (r == 3);
         wr_addr_i = 4'($urandom); wr_data_i = {4'($urandom), 32'($urandom)};
         tick();
      end
      result_valid_i = 1'b0; wr_en_i = 1'b0; start_i = 1'b0;
      check_eq("pass_cnt", pass_cnt_o, 36'(e_pass));
      check_eq("fail_cnt", fail_cnt_o, 36'(e_fail));
      check_eq("timeout", timeout_o, e_to);
      check_eq("last_result", last_result_o, m_last);
      check_eq("index", index_o, 36'(n));
      check_eq("state_idle", state_o, 0);
   endtask

   initial begin
      rst = 1'b1; wr_en_i = 0; start_i = 0; step_mode_i = 0; advance_i = 0;
      result_valid_i = 0; wr_addr_i = '0; wr_data_i = '0; len_i = '0; result_i = '0;
      for (int k = 0; k < DEPTH; k++) begin
         scr[k] = '0; rdly[k] = 0; rval[k] = '0; early[k] = 0;
      end
      tick(); tick();
      rst = 1'b0;
      tick();
      check_eq("rst_busy", busy_o, 0);
      check_eq("rst_press", press_o, 0);
      check_eq("rst_data", data_o, 0);
      check_eq("rst_done", done_o, 0);
      check_eq("rst_state", state_o, 0);
      check_eq("rst_pass", pass_cnt_o, 0);
      check_eq("rst_fail", fail_cnt_o, 0);
      check_eq("rst_timeout", timeout_o, 0);
      check_eq("rst_last", last_result_o, 0);
      check_eq("rst_index", index_o, 0);

      // Directed: matching result, mismatching result, no result, empty run.
      scr[0] = {16'h0032, 8'h05, 8'h0A, 4'h2};
      write_entry(0, scr[0]);
      rdly[0] = 3; rval[0] = 16'h0032; early[0] = 0;
      do_run(1, 0, '0);
      rval[0] = 16'h0031; early[0] = 1;
      do_run(1, 0, '0);
      rdly[0] = -1; early[0] = 0;
      do_run(1, 0, '0);
      do_run(0, 0, '0);

      // Randomized scripts and responses.
      for (int it = 0; it < 12; it++) begin
         int n;
         for (int a = 0; a < DEPTH; a++) begin
            scr[a] = {4'($urandom), 32'($urandom)};
            write_entry(a, scr[a]);
         end
         n = $urandom_range(1, DEPTH);
         for (int k = 0; k < DEPTH; k++) begin
            rdly[k]  = ($urandom_range(0, 3) == 0) ? -1 : $urandom_range(0, TIMEOUT - 1);
            early[k] = $urandom_range(0, 1);
         end
         for (int k = 0; k < DEPTH; k++)
            rval[k] = $urandom_range(0, 1) ? scr[k][35:20] : 16'($urandom);
         if ($urandom_range(0, 1) == 1) begin
            logic [35:0] w;
            w = {4'($urandom), 32'($urandom)};
            rval[0] = w[35:20];
            do_run(n, 1, w);
         end else begin
            do_run(n, 0, '0);
         end
      end

      // Step mode: bytes advance only on advance_i after the strobe cycle.
      scr[0] = {16'h1234, 8'h5A, 8'hC3, 4'h9};
      write_entry(0, scr[0]);
      step_mode_i = 1'b1;
      start_i = 1'b1; len_i = 5'd1;
      tick();
      start_i = 1'b0;
      check_eq("step_load", state_o, 1);
      tick();
      check_eq("step_p_op", press_o, 1);
      check_eq("step_d_op", data_o, 8'h09);
      advance_i = 1'b1;
      tick();
      advance_i = 1'b0;
      check_eq("step_ign_op", press_o, 0);
      check_eq("step_st_op", state_o, 2);
      repeat (3) begin
         tick();
         check_eq("step_hold", press_o, 0);
      end
      advance_i = 1'b1;
      tick();
      advance_i = 1'b0;
      check_eq("step_p_a", press_o, 1);
      check_eq("step_d_a", data_o, 8'hC3);
      advance_i = 1'b1;
      tick();
      advance_i = 1'b0;
      check_eq("step_ign_a", press_o, 0);
      check_eq("step_st_a", state_o, 3);
      check_eq("step_hold_a", data_o, 8'hC3);
      tick();
      advance_i = 1'b1;
      tick();
      advance_i = 1'b0;
      check_eq("step_p_b", press_o, 1);
      check_eq("step_d_b", data_o, 8'h5A);
      tick();
      advance_i = 1'b1;
      tick();
      advance_i = 1'b0;
      check_eq("step_wait", state_o, 5);
      result_valid_i = 1'b1; result_i = 16'h1234;
      tick();
      result_valid_i = 1'b0;
      tick();
      check_eq("step_done", done_o, 1);
      tick();
      step_mode_i = 1'b0;
      check_eq("step_pass", pass_cnt_o, 1);
      check_eq("step_fail", fail_cnt_o, 0);
      check_eq("step_last", last_result_o, 16'h1234);
      m_data = 8'h5A; m_last = 16'h1234;

      // Reset mid-run (SEND_A), then replay from entry 0.
      for (int a = 0; a < 3; a++) begin
         scr[a] = {4'($urandom), 32'($urandom)};
         write_entry(a, scr[a]);
         rdly[a] = $urandom_range(0, 5); rval[a] = scr[a][35:20]; early[a] = 0;
      end
      start_i = 1'b1; len_i = 5'd3;
      tick();
      start_i = 1'b0;
      repeat (6) tick();
      check_eq("pre_rst_press", press_o, 1);
      check_eq("pre_rst_state", state_o, 3);
      rst = 1'b1;
      #1;
      check_eq("mid_rst_press", press_o, 0);
      check_eq("mid_rst_busy", busy_o, 0);
      check_eq("mid_rst_state", state_o, 0);
      check_eq("mid_rst_data", data_o, 0);
      check_eq("mid_rst_index", index_o, 0);
      tick();
      rst = 1'b0;
      m_data = 8'h00; m_last = 16'h0000;
      tick();
      do_run(3, 0, '0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end
endmodule
`default_nettype wire
